// File: rtl/mem_req_pkg.sv
// mem_req_pkg: shared state encoding, line geometry and address alignment helper
package mem_req_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;
  localparam int LINE_BYTES = 64;
  localparam int OFFSET_BITS = $clog2(LINE_BYTES);
  function automatic logic [63:0] line_align(input logic [63:0] addr, input int ob = OFFSET_BITS);
    return addr & ~((64'd1 << ob) - 64'd1);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting at ptr and wrapping to 0
module rr_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int IW = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1
) (
  input  logic [NUM_CORES-1:0] req,
  input  logic [IW-1:0]        ptr,
  output logic [NUM_CORES-1:0] grant,
  output logic [IW-1:0]        idx
);
  logic [IW-1:0] c;
  logic found;
  always_comb begin
    grant = '0;
    idx = '0;
    found = 1'b0;
    c = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      c = IW'((int'(ptr) + i) % NUM_CORES);
      if (!found && req[c]) begin
        found = 1'b1;
        grant[c] = 1'b1;
        idx = c;
      end
    end
  end
endmodule

// File: rtl/mem_request_arbiter.sv
// mem_request_arbiter: round-robin funnel of per-core line requests onto one memory port
module mem_request_arbiter import mem_req_pkg::*; #(
  parameter int NUM_CORES = 4,
  parameter int LINE_BYTES = 64,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = LINE_BYTES * 8,
  parameter int RESP_TIMEOUT = 64
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_CORES-1:0]            core_req_valid,
  input  logic [NUM_CORES-1:0]            core_req_write,
  input  logic [NUM_CORES*ADDR_WIDTH-1:0] core_req_addr,
  input  logic [NUM_CORES*DATA_WIDTH-1:0] core_req_wdata,
  output logic [NUM_CORES-1:0]            core_req_ready,
  output logic [NUM_CORES-1:0]            core_ack,
  output logic [DATA_WIDTH-1:0]           core_resp_rdata,
  output logic                            mem_req_valid,
  output logic                            mem_req_write,
  output logic [ADDR_WIDTH-1:0]           mem_req_addr,
  output logic [DATA_WIDTH-1:0]           mem_req_wdata,
  input  logic                            mem_req_ready,
  input  logic                            mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]           mem_resp_rdata,
  output logic                            err_timeout
);
  localparam int IW = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1;
  localparam int CW = $clog2(RESP_TIMEOUT + 1);
  localparam int OB = $clog2(LINE_BYTES);
  state_t state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, owner_q, owner_d, win_idx;
  logic [NUM_CORES-1:0] win, ack_q, ack_d;
  logic write_q, write_d, err_q, err_d, take;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  rr_arbiter #(.NUM_CORES(NUM_CORES), .IW(IW)) u_rr (
    .req(core_req_valid), .ptr(ptr_q), .grant(win), .idx(win_idx)
  );
  assign core_req_ready = state_q == IDLE ? win : '0;
  assign take = |(core_req_valid & core_req_ready);
  assign core_ack = ack_q;
  assign core_resp_rdata = rdata_q;
  assign mem_req_valid = state_q == ISSUE;
  assign mem_req_write = write_q;
  assign mem_req_addr = addr_q;
  assign mem_req_wdata = wdata_q;
  assign err_timeout = err_q;
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    owner_d = owner_q;
    write_d = write_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d = err_q;
    ack_d = '0;
    cnt_d = cnt_q == '1 ? cnt_q : cnt_q + 1'b1;
    case (state_q)
      IDLE: if (take) begin
        owner_d = win_idx;
        write_d = core_req_write[win_idx];
        addr_d = ADDR_WIDTH'(line_align(64'(core_req_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH]), OB));
        wdata_d = core_req_wdata[win_idx*DATA_WIDTH +: DATA_WIDTH];
        ptr_d = win_idx == IW'(NUM_CORES - 1) ? '0 : win_idx + 1'b1;
        state_d = ISSUE;
      end
      ISSUE: if (mem_req_ready) begin
        ack_d = write_q ? NUM_CORES'(1) << owner_q : '0;
        cnt_d = '0;
        state_d = write_q ? IDLE : WAIT_RD;
      end
      WAIT_RD: if (mem_resp_valid || cnt_q == CW'(RESP_TIMEOUT - 1)) begin
        // a response arriving on the threshold cycle beats the timeout
        rdata_d = mem_resp_valid ? mem_resp_rdata : '0;
        err_d = err_q | ~mem_resp_valid;
        ack_d = NUM_CORES'(1) << owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q <= '0;
      owner_q <= '0;
      write_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
      ack_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      owner_q <= owner_d;
      write_q <= write_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
      ack_q <= ack_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_mem_request_arbiter.sv
// tb_mem_request_arbiter: table-driven transactions plus scoreboard of expected core acks
module tb_mem_request_arbiter;
  localparam int RT = 64;
  logic clk = 1'b0, rst_n;
  logic [3:0] core_req_valid, core_req_write, core_req_ready, core_ack;
  logic [255:0] core_req_addr;
  logic [2047:0] core_req_wdata;
  logic [511:0] core_resp_rdata, mem_req_wdata, mem_resp_rdata;
  logic [63:0] mem_req_addr;
  logic mem_req_valid, mem_req_write, mem_req_ready, mem_resp_valid, err_timeout;
  typedef struct {logic [3:0] ack; logic [511:0] rd; bit chk; bit err;} exp_t;
  typedef struct {
    int c; bit wr; logic [63:0] a; logic [511:0] wd; logic [511:0] rsp;
    logic [63:0] exp_a; logic [511:0] exp_rd; int hold; int rd_delay;
  } vec_t;
  exp_t sbq[$];
  vec_t vecs[9];
  logic [511:0] mem_model[logic [63:0]];
  int nvec = 0, errs = 0;
  bit exp_err = 0;
  mem_request_arbiter dut (
    .clk(clk), .rst_n(rst_n), .core_req_valid(core_req_valid), .core_req_write(core_req_write),
    .core_req_addr(core_req_addr), .core_req_wdata(core_req_wdata), .core_req_ready(core_req_ready),
    .core_ack(core_ack), .core_resp_rdata(core_resp_rdata), .mem_req_valid(mem_req_valid),
    .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .err_timeout(err_timeout)
  );
  always #5 clk = ~clk;
  function automatic logic [511:0] fill(input logic [7:0] b);
    return {64{b}};
  endfunction
  task automatic check(input string nm, input logic [511:0] got, input logic [511:0] exp);
    nvec++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask
  task automatic push(input logic [3:0] ack, input logic [511:0] rd, input bit chk, input bit err);
    exp_t e;
    e.ack = ack;
    e.rd = rd;
    e.chk = chk;
    e.err = err;
    sbq.push_back(e);
  endtask
  always @(posedge clk) begin
    #2;
    if (rst_n === 1'b1 && |core_ack) begin
      if (sbq.size() == 0) begin
        nvec++;
        errs++;
        $display("FAIL sb_unexpected ack got=%b exp=0000", core_ack);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("sb_ack", core_ack, e.ack);
        if (e.chk) check("sb_rdata", core_resp_rdata, e.rd);
        check("sb_err", err_timeout, e.err);
      end
    end
  end
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    core_req_valid = '0;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_err = 0;
    sbq.delete();
  endtask
  task automatic do_txn(input vec_t v);
    int n;
    @(negedge clk);
    core_req_valid = '0;
    core_req_valid[v.c] = 1'b1;
    core_req_write[v.c] = v.wr;
    core_req_addr[v.c*64 +: 64] = v.a;
    core_req_wdata[v.c*512 +: 512] = v.wd;
    #1;
    n = 0;
    while (core_req_ready == 0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("grant", core_req_ready, 4'b1 << v.c);
    @(negedge clk);
    core_req_valid = '0;
    check("mreq_valid", mem_req_valid, 1);
    check("mreq_addr", mem_req_addr, v.exp_a);
    check("mreq_write", mem_req_write, v.wr);
    if (v.wr) check("mreq_wdata", mem_req_wdata, v.wd);
    for (int i = 0; i < v.hold; i++) begin
      core_req_valid = 4'b0010;
      #1;
      check("bp_valid", mem_req_valid, 1);
      check("bp_addr", mem_req_addr, v.exp_a);
      check("bp_wdata", mem_req_wdata, v.wd);
      check("bp_grant", core_req_ready, 0);
      @(negedge clk);
    end
    core_req_valid = '0;
    mem_req_ready = 1'b1;
    if (v.wr) begin
      mem_model[v.exp_a] = mem_req_wdata;
      push(4'b1 << v.c, '0, 0, exp_err);
    end
    @(negedge clk);
    mem_req_ready = 1'b0;
    check("mreq_drop", mem_req_valid, 0);
    if (v.wr) begin
      check("wr_ack", core_ack, 4'b1 << v.c);
    end else if (v.rd_delay >= 0) begin
      repeat (v.rd_delay) @(negedge clk);
      mem_resp_valid = 1'b1;
      mem_resp_rdata = mem_model.exists(v.exp_a) ? mem_model[v.exp_a] : v.rsp;
      push(4'b1 << v.c, v.exp_rd, 1, exp_err);
      @(negedge clk);
      mem_resp_valid = 1'b0;
      check("rd_ack", core_ack, 4'b1 << v.c);
      check("rd_data", core_resp_rdata, v.exp_rd);
    end else begin
      exp_err = 1;
      push(4'b1 << v.c, '0, 1, 1);
      n = 0;
      while (core_ack == 0 && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("to_latency", n, RT);
      check("to_err", err_timeout, 1);
      check("to_rdata", core_resp_rdata, 0);
      mem_resp_valid = 1'b1;
      mem_resp_rdata = fill(8'h77);
      @(negedge clk);
      mem_resp_valid = 1'b0;
      check("late_resp_ack", core_ack, 0);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
  initial begin
    int got, n;
    rst_n = 1'b0;
    core_req_valid = '0;
    core_req_write = '0;
    core_req_addr = '0;
    core_req_wdata = '0;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
    vecs[0] = '{2, 0, 64'h1047, '0, fill(8'hA5), 64'h1040, fill(8'hA5), 0, 0};
    vecs[1] = '{0, 1, 64'h2000, {8{64'h0123456789ABCDEF}}, '0, 64'h2000, '0, 0, 0};
    vecs[2] = '{0, 0, 64'h2000, '0, fill(8'h00), 64'h2000, {8{64'h0123456789ABCDEF}}, 0, 2};
    vecs[3] = '{3, 0, 64'hFFFF_FFFF_FFFF_FFFF, '0, fill(8'h5A), 64'hFFFF_FFFF_FFFF_FFC0, fill(8'h5A), 0, 0};
    vecs[4] = '{1, 1, 64'h1_2345_677F, fill(8'h3C), '0, 64'h1_2345_6740, '0, 0, 0};
    vecs[5] = '{1, 0, 64'h1_2345_6755, '0, fill(8'h00), 64'h1_2345_6740, fill(8'h3C), 0, 1};
    vecs[6] = '{3, 1, 64'h4010, fill(8'hC3), '0, 64'h4000, '0, 10, 0};
    vecs[7] = '{1, 0, 64'h5000, '0, fill(8'h99), 64'h5000, fill(8'h99), 0, RT - 1};
    vecs[8] = '{1, 0, 64'h3008, '0, '0, 64'h3000, '0, 0, -1};
    repeat (3) @(negedge clk);
    check("rst_ready", core_req_ready, 0);
    check("rst_ack", core_ack, 0);
    check("rst_mvalid", mem_req_valid, 0);
    check("rst_maddr", mem_req_addr, 0);
    check("rst_rdata", core_resp_rdata, 0);
    check("rst_err", err_timeout, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) do_txn(vecs[i]);
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 4; i++) core_req_addr[i*64 +: 64] = 64'h8000 + 64'(i * 64);
    core_req_valid = 4'hF;
    core_req_write = 4'hF;
    mem_req_ready = 1'b1;
    got = 0;
    n = 0;
    while (got < 5 && n < 40) begin
      #1;
      if (|core_req_ready) begin
        check($sformatf("rr_grant%0d", got), core_req_ready, 4'b1 << (got % 4));
        push(4'b1 << (got % 4), '0, 0, 0);
        got++;
      end
      @(negedge clk);
      n++;
    end
    core_req_valid = '0;
    check("rr_count", got, 5);
    repeat (3) @(negedge clk);
    mem_req_ready = 1'b0;
    core_req_write = '0;
    do_txn(vecs[8]);
    @(negedge clk);
    core_req_valid = 4'b0100;
    core_req_addr[2*64 +: 64] = 64'h7000;
    @(negedge clk);
    core_req_valid = '0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_ack", core_ack, 0);
    check("mid_rst_mvalid", mem_req_valid, 0);
    check("mid_rst_err", err_timeout, 0);
    check("mid_rst_rdata", core_resp_rdata, 0);
    rst_n = 1'b1;
    exp_err = 0;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = fill(8'hEE);
    @(negedge clk);
    mem_resp_valid = 1'b0;
    check("stray_ack", core_ack, 0);
    @(negedge clk);
    check("stray_ack2", core_ack, 0);
    core_req_valid = 4'b1001;
    core_req_write = 4'b1001;
    #1;
    check("ptr_reset", core_req_ready, 4'b0001);
    push(4'b0001, '0, 0, 0);
    @(negedge clk);
    core_req_valid = '0;
    mem_req_ready = 1'b1;
    repeat (3) @(negedge clk);
    mem_req_ready = 1'b0;
    check("sb_drain", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end
endmodule

// File: doc/mem_request_arbiter.md
# mem_request_arbiter

Initiator side of the shared-memory line interface. Collects 64-byte line-fill reads and writebacks from the per-core cache controllers, picks one at a time with a round-robin policy, and drives the single-port shared memory request/response channel. Only one transaction is in flight at a time. Sits between the four private caches and the shared memory model in the MOESI 4-core system.

## Interface
Parameters:
- NUM_CORES, 4, number of requesting cores
- LINE_BYTES, 64, cache line size in bytes
- ADDR_WIDTH, 64, byte address width
- DATA_WIDTH, LINE_BYTES*8, line data width
- RESP_TIMEOUT, 64, maximum cycles to wait for read data before error

Ports (clk and rst_n: one clock; reset is synchronous and active-low):
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- core_req_valid  in  NUM_CORES  per-core request pending
- core_req_write  in  NUM_CORES  1=writeback, 0=line fill
- core_req_addr  in  NUM_CORES x ADDR_WIDTH  byte address per core
- core_req_wdata  in  NUM_CORES x DATA_WIDTH  writeback data per core
- core_req_ready  out  NUM_CORES  one-hot grant; request accepted on valid&&ready
- core_ack  out  NUM_CORES  one-cycle completion pulse to the owning core
- core_resp_rdata  out  DATA_WIDTH  read data, valid with core_ack for reads
- mem_req_valid  out  1  request to memory
- mem_req_write  out  1  1=write
- mem_req_addr  out  ADDR_WIDTH  line-aligned address
- mem_req_wdata  out  DATA_WIDTH  write data
- mem_req_ready  in  1  memory can accept
- mem_resp_valid  in  1  read data pulse
- mem_resp_rdata  in  DATA_WIDTH  read data
- err_timeout  out  1  sticky read-timeout flag

## Operation
- FSM states: IDLE, ISSUE, WAIT_RD.
- IDLE: core_req_ready is combinational, one-hot, and driven to the round-robin winner among asserted core_req_valid. It is all-zero when no request is valid or the state is not IDLE. On handshake, latch owner, write, addr (low log2(LINE_BYTES) bits cleared), and wdata. Set the RR pointer to owner+1 (mod NUM_CORES). Go to ISSUE.
- ISSUE: mem_req_valid=1 with the latched fields held stable until mem_req_ready=1.
  - On acceptance of a write: pulse core_ack[owner] on the next cycle, then go to IDLE.
  - On acceptance of a read: clear the timeout counter and go to WAIT_RD.
- WAIT_RD: the counter increments each cycle.
  - On mem_resp_valid: register mem_resp_rdata into core_resp_rdata, pulse core_ack[owner] next cycle, go to IDLE.
  - If the counter reaches RESP_TIMEOUT-1 without a response: set err_timeout, pulse core_ack[owner] with core_resp_rdata=0, go to IDLE.
- mem_resp_valid outside WAIT_RD is ignored.
- Round-robin: search starts at the pointer and wraps NUM_CORES-1 -> 0. The pointer resets to 0.

## Timing
- Reset values: all outputs 0, state IDLE, RR pointer 0, err_timeout 0. A reset asserted mid-transaction abandons it without an ack. A late memory response after reset is ignored.
- Grant to mem_req_valid: 1 cycle, registered.
- Write latency: handshake cycle T, mem_req_valid at T+1; with mem_req_ready=1 at T+1, core_ack at T+2.
- Read latency: core_ack occurs one cycle after the mem_resp_valid cycle.
- mem_req_valid never deasserts before acceptance. No new grant is issued until the current core_ack cycle has passed; the next grant can occur in the ack cycle itself, since the FSM is already back in IDLE.
- mem_resp_valid in the same cycle as the timeout threshold: the response wins, err_timeout stays 0.
- core_ack and core_req_ready are never asserted for the same core in the same cycle for the same transaction.
- Counter width: $clog2(RESP_TIMEOUT+1); saturates and does not wrap.

## Structure
- Package mem_req_pkg: state enum (IDLE, ISSUE, WAIT_RD), LINE_BYTES, OFFSET_BITS, and the line-align helper function.
- Sub-module rr_arbiter: NUM_CORES request vector plus pointer in, one-hot grant and encoded index out. Purely combinational; the pointer register lives in the top module.
- Top module holds the FSM, request latch, timeout counter, and response registers.

## Test plan
- Single read: core 2 reads 0x1047 -> mem_req_addr=0x1040, mem_req_write=0. Memory returns 0xA5-filled line -> core_ack=4'b0100 and core_resp_rdata=all 0xA5 exactly one cycle after mem_resp_valid.
- Write then read-back: core 0 writes 0x2000 with pattern 0x0123…, then reads 0x2000 -> core_ack for the write at T+2, and the read returns the identical pattern.
- Round-robin fairness: all four cores hold valid continuously with pointer=0 -> grant order 0,1,2,3,0. No core is granted twice before the others.
- Backpressure: hold mem_req_ready=0 for 10 cycles during ISSUE -> mem_req_valid/addr/wdata stay stable, no grants occur, and exactly one acceptance follows.
- Timeout: memory never responds to a core 1 read -> after RESP_TIMEOUT cycles err_timeout=1 and core_ack[1] pulses with rdata=0; a later mem_resp_valid is ignored.
- Reset mid-read: assert rst_n=0 in WAIT_RD -> all outputs 0 next cycle, no ack, pointer=0; the subsequent stray mem_resp_valid produces no ack.
